// File: rtl/cdb_driver.sv
// CDB producer: four lanes, each a two-source round-robin front end over a FIFO.
// Optional macro CDB_BYPASS_EN lets a result into an empty lane skip the FIFO.
module cdb_driver #(
    parameter int DEPTH = 4
) (
    input  logic         CLK,
    input  logic         Reset,
    input  logic         Flush,
    input  logic [7:0]   in_valid,
    input  logic [23:0]  in_tag,
    input  logic [255:0] in_value,
    input  logic [7:0]   in_wb,
    output logic [7:0]   in_ready,
    output logic [147:0] CDB,
    output logic         DP_WriteBack,
    output logic         MEM_WriteBack
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [3:0] wb_all;
    logic       unused_wb;

    assign CDB[147:144]  = 4'b0;
    assign DP_WriteBack  = wb_all[0];
    assign MEM_WriteBack = wb_all[1];
    assign unused_wb     = ^wb_all[3:2];

    for (genvar l = 0; l < 4; l++) begin : g_lane
        localparam int SA = 2 * l;
        localparam int SB = 2 * l + 1;

        // entry layout: {wb, value[31:0], tag[2:0]}
        logic [35:0]   mem [DEPTH];
        logic [PW-1:0] rd_ptr;
        logic [PW-1:0] wr_ptr;
        logic [CW-1:0] count;
        logic [CW-1:0] free;
        logic          rr;
        logic [35:0]   cdb_q;
        logic          wb_q;

        logic [35:0] ent_a, ent_b, f_d, s_d;
        logic [35:0] e0, e1, q0, q1, head, bc_data;
        logic        rdy_a, rdy_b, xa, xb;
        logic        f_v, s_v, e0_v, e1_v;
        logic        q0_v, q1_v, bc_valid, pop;
        logic [1:0]  n_enq;

        assign ent_a = {in_wb[SA], in_value[32*SA +: 32], in_tag[3*SA +: 3]};
        assign ent_b = {in_wb[SB], in_value[32*SB +: 32], in_tag[3*SB +: 3]};
        assign head  = mem[rd_ptr];

        always_comb begin
            free  = CW'(DEPTH) - count;
            rdy_a = 1'b0;
            rdy_b = 1'b0;
            if (!Flush) begin
                if (free >= CW'(2)) begin
                    rdy_a = 1'b1;
                    rdy_b = 1'b1;
                end else if (free == CW'(1)) begin
                    rdy_a = !rr;
                    rdy_b = rr;
                end
            end
            xa = in_valid[SA] & rdy_a;
            xb = in_valid[SB] & rdy_b;

            // order the accepted results: priority source first
            f_v  = rr ? xb : xa;
            f_d  = rr ? ent_b : ent_a;
            s_v  = rr ? xa : xb;
            s_d  = rr ? ent_a : ent_b;
            e0_v = f_v | s_v;
            e0   = f_v ? f_d : s_d;
            e1_v = f_v & s_v;
            e1   = s_d;

            pop      = (count != '0);
            bc_valid = pop;
            bc_data  = head;
            q0_v     = e0_v;
            q0       = e0;
            q1_v     = e1_v;
            q1       = e1;
`ifdef CDB_BYPASS_EN
            if (count == '0) begin
                bc_valid = e0_v;
                bc_data  = e0;
                q0_v     = e1_v;
                q0       = e1;
                q1_v     = 1'b0;
            end
`endif
            n_enq = {1'b0, q0_v} + {1'b0, q1_v};
        end

        always_ff @(posedge CLK or posedge Reset) begin
            if (Reset) begin
                count  <= '0;
                rd_ptr <= '0;
                wr_ptr <= '0;
                rr     <= 1'b0;
                cdb_q  <= '0;
                wb_q   <= 1'b0;
            end else if (Flush) begin
                count  <= '0;
                rd_ptr <= '0;
                wr_ptr <= '0;
                rr     <= 1'b0;
                cdb_q  <= '0;
                wb_q   <= 1'b0;
            end else begin
                count  <= count + CW'(n_enq) - CW'(pop);
                rd_ptr <= rd_ptr + PW'(pop);
                wr_ptr <= wr_ptr + PW'(n_enq);
                rr     <= rr ^ f_v;
                cdb_q  <= bc_valid ? {bc_data[34:3], 1'b1, bc_data[2:0]} : '0;
                wb_q   <= bc_valid & bc_data[35];
            end
        end

        always_ff @(posedge CLK) begin
            if (q0_v)
                mem[wr_ptr] <= q0;
            if (q1_v)
                mem[wr_ptr + PW'(1)] <= q1;
        end

        assign in_ready[SA]    = rdy_a;
        assign in_ready[SB]    = rdy_b;
        assign CDB[36*l +: 36] = cdb_q;
        assign wb_all[l]       = wb_q;
    end

endmodule

// File: tb/tb_cdb_driver.sv
// Randomized bench for cdb_driver: queue-based lane model feeds a
// scoreboard that a negedge monitor drains against the CDB broadcasts.
module tb_cdb_driver;
    localparam int DEPTH = 4;

    logic         CLK = 1'b0;
    logic         Reset;
    logic         Flush;
    logic [7:0]   in_valid;
    logic [23:0]  in_tag;
    logic [255:0] in_value;
    logic [7:0]   in_wb;
    logic [7:0]   in_ready;
    logic [147:0] CDB;
    logic         DP_WriteBack;
    logic         MEM_WriteBack;

    cdb_driver #(.DEPTH(DEPTH)) dut (
        .CLK(CLK),
        .Reset(Reset),
        .Flush(Flush),
        .in_valid(in_valid),
        .in_tag(in_tag),
        .in_value(in_value),
        .in_wb(in_wb),
        .in_ready(in_ready),
        .CDB(CDB),
        .DP_WriteBack(DP_WriteBack),
        .MEM_WriteBack(MEM_WriteBack)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int          due;
        logic [35:0] e;
    } sb_t;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    bit          mon_en = 0;
    sb_t         sb[4][$];
    logic [35:0] mq[4][$];
    bit          mrr[4];
    logic [7:0]  dv;
    logic [2:0]  dtag[8];
    logic [31:0] dval[8];
    logic        dwb[8];

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [147:0] act, input logic [147:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %h, want %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [35:0] ent(input int s);
        return {dwb[s], dval[s], dtag[s]};
    endfunction

    task automatic rand_data();
        for (int s = 0; s < 8; s++) begin
            dtag[s] = 3'($urandom_range(0, 7));
            dval[s] = $urandom;
            dwb[s]  = 1'($urandom_range(0, 1));
        end
    endtask

    // One cycle: drive, predict ready, advance model, wait for the edge.
    task automatic step(input bit fl);
        logic [7:0]  er;
        logic [35:0] acc[$];
        int          pri, oth, fr;
        bit          xp, xo;
        Flush    = fl;
        in_valid = dv;
        for (int s = 0; s < 8; s++) begin
            in_tag[3*s +: 3]    = dtag[s];
            in_value[32*s +: 32] = dval[s];
            in_wb[s]            = dwb[s];
        end
        #1;
        er = '0;
        for (int l = 0; l < 4; l++) begin
            fr = DEPTH - mq[l].size();
            if (!fl && fr >= 2) begin
                er[2*l]   = 1'b1;
                er[2*l+1] = 1'b1;
            end else if (!fl && fr == 1) begin
                er[2*l + (mrr[l] ? 1 : 0)] = 1'b1;
            end
        end
        chk("in_ready", 148'(in_ready), 148'(er));
        for (int l = 0; l < 4; l++) begin
            if (fl) begin
                mq[l].delete();
                mrr[l] = 0;
            end else begin
                pri = mrr[l] ? 2*l + 1 : 2*l;
                oth = mrr[l] ? 2*l : 2*l + 1;
                xp  = dv[pri] & er[pri];
                xo  = dv[oth] & er[oth];
                acc.delete();
                if (xp) acc.push_back(ent(pri));
                if (xo) acc.push_back(ent(oth));
                if (xp) mrr[l] = !mrr[l];
                if (mq[l].size() > 0) begin
                    sb[l].push_back('{cyc + 1, mq[l].pop_front()});
                end
`ifdef CDB_BYPASS_EN
                else if (acc.size() > 0) begin
                    sb[l].push_back('{cyc + 1, acc.pop_front()});
                end
`endif
                foreach (acc[i]) mq[l].push_back(acc[i]);
            end
        end
        @(posedge CLK);
        #1;
    endtask

    logic [35:0] mlane;
    logic        mwb;
    sb_t         mexp;

    always @(negedge CLK) begin
        if (mon_en && !Reset) begin
            chk("cdb_top", 148'(CDB[147:144]), '0);
            for (int l = 0; l < 4; l++) begin
                mlane = CDB[36*l +: 36];
                mwb   = (l == 0) ? DP_WriteBack : (l == 1) ? MEM_WriteBack : 1'b0;
                if (mlane[3]) begin
                    if (sb[l].size() == 0) begin
                        chk("unexpected_bcast", 148'({mlane, mwb}), '0);
                    end else begin
                        mexp = sb[l].pop_front();
                        chk("bcast_data", 148'({mlane, mwb}),
                            148'({mexp.e[34:3], 1'b1, mexp.e[2:0],
                                  (l < 2) ? mexp.e[35] : 1'b0}));
                        chk("bcast_cycle", 148'(cyc), 148'(mexp.due));
                    end
                end else if (sb[l].size() > 0 && sb[l][0].due <= cyc) begin
                    mexp = sb[l].pop_front();
                    chk("missing_bcast", 148'(mlane), 148'({mexp.e[34:3], 1'b1, mexp.e[2:0]}));
                end else begin
                    chk("idle_lane", 148'({mlane, mwb}), '0);
                end
            end
        end
    end

    initial begin
        Reset    = 1'b1;
        Flush    = 1'b0;
        in_valid = '0;
        in_tag   = '0;
        in_value = '0;
        in_wb    = '0;
        dv       = '0;
        rand_data();
        #1;
        chk("reset_cdb", CDB, '0);
        chk("reset_wb", 148'({DP_WriteBack, MEM_WriteBack}), '0);
        repeat (2) @(posedge CLK);
        #3;
        Reset = 1'b0;
        @(posedge CLK);
        #1;
        mon_en = 1;

        // single result on lane 2 source A
        dv       = 8'h10;
        dtag[4]  = 3'd5;
        dval[4]  = 32'hDEADBEEF;
        step(0);
`ifdef CDB_BYPASS_EN
        chk("single_k", 148'(CDB[107:72]), 148'({32'hDEADBEEF, 1'b1, 3'd5}));
`else
        chk("single_k", 148'(CDB[107:72]), '0);
`endif
        dv = '0;
        step(0);
`ifdef CDB_BYPASS_EN
        chk("single_k1", 148'(CDB[107:72]), '0);
`else
        chk("single_k1", 148'(CDB[107:72]), 148'({32'hDEADBEEF, 1'b1, 3'd5}));
`endif
        step(0);
        chk("single_k2", 148'(CDB[107:72]), '0);

        // dual enqueue on lane 0
        dv      = 8'h03;
        dtag[0] = 3'd1;
        dwb[0]  = 1'b1;
        dtag[1] = 3'd2;
        dwb[1]  = 1'b0;
        step(0);
        dv = '0;
        repeat (4) step(0);

        // saturation on lane 1
        dv = 8'h0C;
        for (int i = 0; i < 10; i++) begin
            rand_data();
            dtag[2] = 3'(2*i);
            dtag[3] = 3'(2*i + 1);
            step(0);
        end
        dv = '0;
        repeat (DEPTH + 2) step(0);

        // wrap-around on lane 3
        dv = 8'h40;
        for (int i = 0; i < 9; i++) begin
            rand_data();
            dtag[6] = 3'(i % 8);
            step(0);
        end
        dv = '0;
        repeat (3) step(0);

        // flush with lane 0 holding entries and inputs valid
        dv = 8'h03;
        rand_data();
        step(0);
        rand_data();
        step(0);
        dv = 8'hFF;
        rand_data();
        step(1);
        chk("flush_cdb", CDB, '0);
        dv = '0;
        repeat (3) step(0);

        // asynchronous reset mid-broadcast
        dv = 8'h0F;
        rand_data();
        step(0);
        rand_data();
        step(0);
        dv       = '0;
        in_valid = '0;
        #2;
        Reset = 1'b1;
        #1;
        chk("async_rst_cdb", CDB, '0);
        chk("async_rst_wb", 148'({DP_WriteBack, MEM_WriteBack}), '0);
        for (int l = 0; l < 4; l++) begin
            sb[l].delete();
            mq[l].delete();
            mrr[l] = 0;
        end
        @(posedge CLK);
        #3;
        Reset = 1'b0;
        @(posedge CLK);
        #1;
        step(0);

        // random traffic, light then heavy
        for (int i = 0; i < 400; i++) begin
            dv = (i < 200) ? 8'($urandom) : 8'($urandom | $urandom);
            rand_data();
            step($urandom_range(0, 99) < 3);
        end

        dv = '0;
        repeat (DEPTH + 3) step(0);
        for (int l = 0; l < 4; l++)
            chk("drained", 148'(sb[l].size()), '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
